// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage data-memory sequencer: splits each 32-bit load/store into two
// 16-bit accesses on a single-port SRAM and stalls the pipeline until done.
module mem_stage_sram_ctrl #(
  parameter int unsigned SRAM_AW     = 18,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_R_EN,
  input  logic               MEM_W_EN,
  input  logic [31:0]        address,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_we_n
);

  localparam int unsigned CntW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               op_wr_q;
  logic [SRAM_AW-2:0] w_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rdata_q;

  logic               req;
  logic               accept;
  logic               last;
  logic               rd_lo, rd_hi;
  logic [31:0]        byte_off;
  logic [SRAM_AW-2:0] w_idx;
  logic               unused_addr;

  assign req = MEM_R_EN | MEM_W_EN;

  // Word index relative to the SRAM window; upper bits drop out so
  // out-of-range addresses wrap silently.
  assign byte_off    = address - BASE_ADDR;
  assign w_idx       = byte_off[SRAM_AW:2];
  assign unused_addr = ^{byte_off[31:SRAM_AW+1], byte_off[1:0]};

  assign last  = (cnt_q == CntW'(WAIT_CYCLES - 1));
  assign rd_lo = (state_q == StLo) && !op_wr_q && last;
  assign rd_hi = (state_q == StHi) && !op_wr_q && last;
  assign rdata = rdata_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      w_q     <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        op_wr_q <= MEM_W_EN;
        w_q     <= w_idx;
        wdata_q <= wdata;
      end
      if (rd_lo) rdata_q[15:0]  <= sram_dq_in;
      if (rd_hi) rdata_q[31:16] <= sram_dq_in;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    accept      = 1'b0;
    ready       = 1'b1;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    case (state_q)
      StIdle: begin
        ready = ~req;
        if (req) begin
          accept  = 1'b1;
          cnt_d   = '0;
          state_d = StLo;
        end
      end
      StLo: begin
        ready     = 1'b0;
        sram_addr = {w_q, 1'b0};
        if (op_wr_q) begin
          sram_dq_out = wdata_q[15:0];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end
        if (last) begin
          cnt_d   = '0;
          state_d = StHi;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHi: begin
        ready     = 1'b0;
        sram_addr = {w_q, 1'b1};
        if (op_wr_q) begin
          sram_dq_out = wdata_q[31:16];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end
        if (last) begin
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        ready   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench for mem_stage_sram_ctrl with a 16-entry halfword SRAM model
// (indexed by the low address bits) and hand-computed expectations.
module tb_mem_stage_sram_ctrl;

  logic        clk;
  logic        rst;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;

  logic [15:0] mem [0:15];
  int          checks;
  int          failures;

  mem_stage_sram_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .MEM_R_EN   (MEM_R_EN),
    .MEM_W_EN   (MEM_W_EN),
    .address    (address),
    .wdata      (wdata),
    .rdata      (rdata),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_in (sram_dq_in),
    .sram_we_n  (sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign sram_dq_in = mem[sram_addr[3:0]];

  // Writes are captured mid-cycle, matching what the SRAM commits on the next edge.
  task automatic tick();
    @(negedge clk);
    if (!sram_we_n && sram_dq_oe) mem[sram_addr[3:0]] = sram_dq_out;
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b0; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; address = '0; wdata = '0;
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(); #1;
      checks++;
      if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || rdata !== 32'h0
          || sram_addr !== 18'h0) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got ready=%b we_n=%b oe=%b rdata=%h addr=%h exp 1 1 0 0 0",
                 i, ready, sram_we_n, sram_dq_oe, rdata, sram_addr);
      end
    end
  endtask

  task automatic test_store();
    MEM_W_EN = 1'b1; address = 32'd1024; wdata = 32'hDEADBEEF; #1;
    checks++;
    if (ready !== 1'b0) begin
      failures++; $display("FAIL store_accept_ready got=%b exp=0", ready);
    end
    for (int i = 1; i <= 4; i++) begin
      logic [17:0] ea;
      logic [15:0] ed;
      ea = (i <= 2) ? 18'd0 : 18'd1;
      ed = (i <= 2) ? 16'hBEEF : 16'hDEAD;
      tick(); #1;
      checks++;
      if (ready !== 1'b0 || sram_addr !== ea || sram_dq_out !== ed || sram_we_n !== 1'b0
          || sram_dq_oe !== 1'b1) begin
        failures++;
        $display("FAIL store_phase cyc=%0d got ready=%b addr=%h dq=%h we_n=%b oe=%b exp 0 %h %h 0 1",
                 i, ready, sram_addr, sram_dq_out, sram_we_n, sram_dq_oe, ea, ed);
      end
    end
    tick(); #1;
    checks++;
    if (ready !== 1'b1 || sram_we_n !== 1'b1) begin
      failures++; $display("FAIL store_done got ready=%b we_n=%b exp 1 1", ready, sram_we_n);
    end
    MEM_W_EN = 1'b0;
    tick(); #1;
    checks++;
    if (mem[0] !== 16'hBEEF || mem[1] !== 16'hDEAD || ready !== 1'b1) begin
      failures++;
      $display("FAIL store_mem got m0=%h m1=%h ready=%b exp beef dead 1", mem[0], mem[1], ready);
    end
  endtask

  task automatic test_load();
    mem[0] = 16'hBEEF; mem[1] = 16'hDEAD;
    MEM_R_EN = 1'b1; address = 32'd1024; #1;
    checks++;
    if (ready !== 1'b0) begin
      failures++; $display("FAIL load_accept_ready got=%b exp=0", ready);
    end
    for (int i = 1; i <= 4; i++) begin
      logic [17:0] ea;
      ea = (i <= 2) ? 18'd0 : 18'd1;
      tick(); #1;
      checks++;
      if (ready !== 1'b0 || sram_addr !== ea || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
        failures++;
        $display("FAIL load_phase cyc=%0d got ready=%b addr=%h we_n=%b oe=%b exp 0 %h 1 0",
                 i, ready, sram_addr, sram_we_n, sram_dq_oe, ea);
      end
    end
    tick(); #1;
    checks++;
    if (ready !== 1'b1 || rdata !== 32'hDEADBEEF) begin
      failures++; $display("FAIL load_done got ready=%b rdata=%h exp 1 deadbeef", ready, rdata);
    end
    MEM_R_EN = 1'b0;
    tick();
  endtask

  task automatic test_both();
    mem[4] = 16'h0; mem[5] = 16'h0;
    MEM_R_EN = 1'b1; MEM_W_EN = 1'b1; address = 32'd1032; wdata = 32'h12345678; #1;
    for (int i = 1; i <= 4; i++) begin
      logic [17:0] ea;
      logic [15:0] ed;
      ea = (i <= 2) ? 18'd4 : 18'd5;
      ed = (i <= 2) ? 16'h5678 : 16'h1234;
      tick(); #1;
      checks++;
      if (sram_addr !== ea || sram_dq_out !== ed || sram_we_n !== 1'b0) begin
        failures++;
        $display("FAIL both_phase cyc=%0d got addr=%h dq=%h we_n=%b exp %h %h 0",
                 i, sram_addr, sram_dq_out, sram_we_n, ea, ed);
      end
    end
    tick(); #1;
    MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
    tick(); #1;
    checks++;
    if (mem[4] !== 16'h5678 || mem[5] !== 16'h1234 || rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL both_result got m4=%h m5=%h rdata=%h exp 5678 1234 deadbeef",
               mem[4], mem[5], rdata);
    end
  endtask

  task automatic test_reset_mid();
    MEM_W_EN = 1'b1; address = 32'd1040; wdata = 32'hCAFEF00D;
    tick(); tick(); tick(); #1;
    checks++;
    if (sram_addr !== 18'd9 || sram_we_n !== 1'b0) begin
      failures++; $display("FAIL rstmid_in_hi got addr=%h we_n=%b exp 9 0", sram_addr, sram_we_n);
    end
    rst = 1'b0;
    tick(); #1;
    checks++;
    if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || ready !== 1'b0 || sram_addr !== 18'h0) begin
      failures++;
      $display("FAIL rstmid_abort got we_n=%b oe=%b ready=%b addr=%h exp 1 0 0 0",
               sram_we_n, sram_dq_oe, ready, sram_addr);
    end
    mem[8] = 16'h0; mem[9] = 16'h0;
    tick(); #1;
    checks++;
    if (mem[8] !== 16'h0 || mem[9] !== 16'h0 || sram_we_n !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_no_strobe got m8=%h m9=%h we_n=%b exp 0 0 1", mem[8], mem[9], sram_we_n);
    end
    rst = 1'b1; #1;
    checks++;
    if (ready !== 1'b0) begin
      failures++; $display("FAIL rstmid_reissue_ready got=%b exp=0", ready);
    end
    for (int i = 1; i <= 4; i++) begin
      logic [17:0] ea;
      ea = (i <= 2) ? 18'd8 : 18'd9;
      tick(); #1;
      checks++;
      if (ready !== 1'b0 || sram_addr !== ea || sram_we_n !== 1'b0) begin
        failures++;
        $display("FAIL rstmid_phase cyc=%0d got ready=%b addr=%h we_n=%b exp 0 %h 0",
                 i, ready, sram_addr, sram_we_n, ea);
      end
    end
    tick(); #1;
    MEM_W_EN = 1'b0;
    tick(); #1;
    checks++;
    if (mem[8] !== 16'hF00D || mem[9] !== 16'hCAFE) begin
      failures++; $display("FAIL rstmid_mem got m8=%h m9=%h exp f00d cafe", mem[8], mem[9]);
    end
  endtask

  task automatic test_back_to_back();
    mem[2] = 16'h1111; mem[3] = 16'h2222; mem[4] = 16'h4444; mem[5] = 16'h5555;
    mem[6] = 16'h6666; mem[7] = 16'h7777;
    MEM_R_EN = 1'b1; address = 32'd1028; #1;
    for (int i = 1; i <= 4; i++) begin
      logic [17:0] ea;
      ea = (i <= 2) ? 18'd2 : 18'd3;
      tick(); #1;
      if (i == 1) begin
        address = 32'd1036; #1;
      end
      checks++;
      if (sram_addr !== ea) begin
        failures++; $display("FAIL b2b_first_addr cyc=%0d got=%h exp=%h", i, sram_addr, ea);
      end
    end
    tick(); #1;
    checks++;
    if (ready !== 1'b1 || rdata !== 32'h22221111) begin
      failures++; $display("FAIL b2b_first_done got ready=%b rdata=%h exp 1 22221111", ready, rdata);
    end
    tick(); #1;
    checks++;
    if (ready !== 1'b0 || sram_we_n !== 1'b1 || sram_addr !== 18'h0) begin
      failures++;
      $display("FAIL b2b_second_idle got ready=%b we_n=%b addr=%h exp 0 1 0", ready, sram_we_n, sram_addr);
    end
    for (int i = 1; i <= 4; i++) begin
      logic [17:0] ea;
      ea = (i <= 2) ? 18'd6 : 18'd7;
      tick(); #1;
      checks++;
      if (ready !== 1'b0 || sram_addr !== ea) begin
        failures++;
        $display("FAIL b2b_second_phase cyc=%0d got ready=%b addr=%h exp 0 %h", i, ready, sram_addr, ea);
      end
    end
    tick(); #1;
    checks++;
    if (ready !== 1'b1 || rdata !== 32'h77776666) begin
      failures++; $display("FAIL b2b_second_done got ready=%b rdata=%h exp 1 77776666", ready, rdata);
    end
    MEM_R_EN = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    logic [31:0] addrs [2];
    logic [17:0] lo_exp [2];
    addrs[0] = 32'd1020;   lo_exp[0] = 18'h3FFFE;
    addrs[1] = 32'd525312; lo_exp[1] = 18'h00000;
    for (int k = 0; k < 2; k++) begin
      MEM_R_EN = 1'b1; address = addrs[k]; #1;
      tick(); #1;
      checks++;
      if (sram_addr !== lo_exp[k]) begin
        failures++; $display("FAIL wrap_lo addr=%0d got=%h exp=%h", addrs[k], sram_addr, lo_exp[k]);
      end
      tick(); tick(); #1;
      checks++;
      if (sram_addr !== (lo_exp[k] | 18'h1)) begin
        failures++;
        $display("FAIL wrap_hi addr=%0d got=%h exp=%h", addrs[k], sram_addr, lo_exp[k] | 18'h1);
      end
      tick(); tick(); #1;
      MEM_R_EN = 1'b0;
      tick();
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 16; i++) mem[i] = 16'h0;
    test_reset();
    test_store();
    test_load();
    test_both();
    test_reset_mid();
    test_back_to_back();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
